// File: rtl/attn_score_sched.sv
// attn_score_sched: per-row MAC/exp sequencer for attention scores.
// Streams q.k pairs, drains the MAC, registers exp, emits on credit.
module attn_score_sched #(
    parameter int LEN_W   = 8,
    parameter int ROW_W   = 8,
    parameter int CREDITS = 4,
    parameter int CRED_W  = 3,
    parameter int MAC_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [ROW_W-1:0]  cfg_rows,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mac_clr,
    output logic              mac_en,
    input  logic [7:0]        mac_result,
    output logic [7:0]        ex_arg,
    input  logic [8:0]        ex_result,
    output logic              out_valid,
    output logic [8:0]        out_data,
    input  logic              credit_ret,
    output logic [CRED_W-1:0] credits
);

    localparam int WAIT_W = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ACC,
        DRAIN,
        EXP,
        EMIT
    } state_t;

    state_t state, state_nxt;

    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  elem_cnt;
    logic [ROW_W-1:0]  rows_q;
    logic [ROW_W-1:0]  row_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    logic cfg_ok;
    logic accept;
    logic last_elem;
    logic last_row;
    logic last_wait;
    logic emit;

    assign cfg_ok    = (cfg_len != '0) && (cfg_rows != '0);
    assign accept    = (state == ACC) && in_valid;
    assign last_elem = (elem_cnt == len_q - LEN_W'(1));
    assign last_row  = (row_cnt == rows_q - ROW_W'(1));
    assign last_wait = (wait_cnt == WAIT_W'(1));
    assign emit      = (state == EMIT) && (credits != '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake/control outputs
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        in_ready  = 1'b0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && cfg_ok) state_nxt = CLR;
            end
            CLR: begin
                mac_clr   = 1'b1;
                state_nxt = ACC;
            end
            ACC: begin
                in_ready = 1'b1;
                mac_en   = in_valid;
                if (accept && last_elem) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (last_wait) state_nxt = EXP;
            end
            EXP: begin
                state_nxt = EMIT;
            end
            EMIT: begin
                out_valid = emit;
                if (emit) begin
                    done      = last_row;
                    state_nxt = last_row ? IDLE : CLR;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Config latch, counters and the two data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q    <= '0;
            rows_q   <= '0;
            row_cnt  <= '0;
            elem_cnt <= '0;
            wait_cnt <= '0;
            ex_arg   <= '0;
            out_data <= '0;
        end else begin
            if (state == IDLE && start && cfg_ok) begin
                len_q   <= cfg_len;
                rows_q  <= cfg_rows;
                row_cnt <= '0;
            end
            if (state == CLR) elem_cnt <= '0;
            if (accept) elem_cnt <= elem_cnt + LEN_W'(1);
            if (accept && last_elem) wait_cnt <= WAIT_W'(MAC_LAT);
            if (state == DRAIN) begin
                if (last_wait) ex_arg <= mac_result;
                else           wait_cnt <= wait_cnt - WAIT_W'(1);
            end
            if (state == EXP) out_data <= ex_result;
            if (emit && !last_row) row_cnt <= row_cnt + ROW_W'(1);
        end
    end

    // Credit counter: emit consumes, credit_ret refills, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= CRED_W'(CREDITS);
        end else if (emit && !credit_ret) begin
            credits <= credits - CRED_W'(1);
        end else if (!emit && credit_ret
                     && credits != CRED_W'(CREDITS)) begin
            credits <= credits + CRED_W'(1);
        end
    end

endmodule

// File: tb/tb_attn_score_sched.sv
// tb_attn_score_sched: scenario tasks with a queue scoreboard.
// u_dut uses default CREDITS; u_dut2 runs with CREDITS=2.
module tb_attn_score_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] cfg_len = '0;
    logic [7:0] cfg_rows = '0;
    logic       in_valid = 1'b0;
    logic [7:0] mac_result = '0;
    logic       credit_ret = 1'b0;

    logic       busy, done, in_ready, mac_clr, mac_en, out_valid;
    logic [7:0] ex_arg;
    logic [8:0] ex_result, out_data;
    logic [2:0] credits;

    logic       busy2, done2, in_ready2, mac_clr2, mac_en2, out_valid2;
    logic [7:0] ex_arg2;
    logic [8:0] ex_result2, out_data2;
    logic [2:0] credits2;

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    assign ex_result  = {1'b0, ex_arg} + 9'd1;
    assign ex_result2 = {1'b0, ex_arg2} + 9'd1;

    attn_score_sched u_dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_len(cfg_len), .cfg_rows(cfg_rows),
        .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready),
        .mac_clr(mac_clr), .mac_en(mac_en),
        .mac_result(mac_result), .ex_arg(ex_arg),
        .ex_result(ex_result), .out_valid(out_valid),
        .out_data(out_data), .credit_ret(credit_ret),
        .credits(credits)
    );

    attn_score_sched #(.CREDITS(2), .CRED_W(3)) u_dut2 (
        .clk(clk), .rst(rst), .start(start),
        .cfg_len(cfg_len), .cfg_rows(cfg_rows),
        .busy(busy2), .done(done2),
        .in_valid(in_valid), .in_ready(in_ready2),
        .mac_clr(mac_clr2), .mac_en(mac_en2),
        .mac_result(mac_result), .ex_arg(ex_arg2),
        .ex_result(ex_result2), .out_valid(out_valid2),
        .out_data(out_data2), .credit_ret(credit_ret),
        .credits(credits2)
    );

    function automatic logic [8:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        credit_ret = 1'b0; cfg_len = '0; cfg_rows = '0;
        mac_result = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({busy, done, in_ready, mac_clr, mac_en, out_valid} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {busy, done, in_ready, mac_clr, mac_en, out_valid});
        end
        n_tests++;
        if ({ex_arg, out_data} !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h want 0/0", ex_arg, out_data);
        end
        n_tests++;
        if (credits !== 3'd4 || credits2 !== 3'd2) begin
            n_fail++;
            $display("FAIL reset_credits: got %0d/%0d want 4/2", credits, credits2);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_row();
        int n_clr = 0;
        int n_en = 0;
        int last = -100;
        logic got = 1'b0;
        logic [8:0] exp;
        do_reset();
        cfg_len = 8'd4; cfg_rows = 8'd1; mac_result = 8'h20;
        in_valid = 1'b1;
        exp_q.push_back(9'h021);
        pulse_start();
        for (int c = 0; c < 40 && !got; c++) begin
            #1;
            if (mac_clr) n_clr++;
            if (mac_en) begin n_en++; last = c; end
            if (out_valid) begin
                got = 1'b1;
                exp = pop_exp();
                n_tests++;
                if (out_data !== exp) begin
                    n_fail++;
                    $display("FAIL single_data: got %h want %h", out_data, exp);
                end
                n_tests++;
                if (ex_arg !== 8'h20) begin
                    n_fail++;
                    $display("FAIL single_exarg: got %h want 20", ex_arg);
                end
                n_tests++;
                if (done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_done: got %b want 1", done);
                end
                n_tests++;
                if (c != last + 3) begin
                    n_fail++;
                    $display("FAIL single_latency: got %0d want %0d", c - last, 3);
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL single_timeout: got no out_valid want one");
        end
        n_tests++;
        if (n_clr != 1 || n_en != 4) begin
            n_fail++;
            $display("FAIL single_counts: got clr=%0d en=%0d want 1/4", n_clr, n_en);
        end
        #1;
        n_tests++;
        if (credits !== 3'd3 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after: got cred=%0d busy=%b want 3/0", credits, busy);
        end
    endtask

    task automatic test_credit_exhaust();
        int emits = 0;
        logic [8:0] exp;
        do_reset();
        cfg_len = 8'd2; cfg_rows = 8'd3; mac_result = 8'h40;
        in_valid = 1'b1;
        repeat (3) exp_q.push_back(9'h041);
        pulse_start();
        for (int c = 0; c < 60 && emits < 2; c++) begin
            #1;
            if (out_valid2) begin
                exp = pop_exp();
                emits++;
                n_tests++;
                if (out_data2 !== exp || done2 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL exhaust_emit: got %h done=%b want %h done=0",
                             out_data2, done2, exp);
                end
            end
            @(negedge clk);
        end
        n_tests++;
        if (emits != 2) begin
            n_fail++;
            $display("FAIL exhaust_first_two: got %0d emits want 2", emits);
        end
        repeat (8) @(negedge clk);
        #1;
        n_tests++;
        if (busy2 !== 1'b1 || out_valid2 !== 1'b0 || credits2 !== 3'd0) begin
            n_fail++;
            $display("FAIL exhaust_stall: got busy=%b ov=%b cred=%0d want 1/0/0",
                     busy2, out_valid2, credits2);
        end
        n_tests++;
        if (out_data2 !== 9'h041) begin
            n_fail++;
            $display("FAIL exhaust_hold: got %h want 041", out_data2);
        end
        @(negedge clk);
        credit_ret = 1'b1;
        #1;
        n_tests++;
        if (out_valid2 !== 1'b0) begin
            n_fail++;
            $display("FAIL exhaust_ret_cycle: got ov=%b want 0", out_valid2);
        end
        @(negedge clk);
        credit_ret = 1'b0;
        #1;
        exp = pop_exp();
        n_tests++;
        if (out_valid2 !== 1'b1 || done2 !== 1'b1 || out_data2 !== exp) begin
            n_fail++;
            $display("FAIL exhaust_third: got ov=%b done=%b d=%h want 1/1/%h",
                     out_valid2, done2, out_data2, exp);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (credits2 !== 3'd0 || busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL exhaust_final: got cred=%0d busy=%b want 0/0", credits2, busy2);
        end
    endtask

    task automatic test_simultaneous();
        int emits = 0;
        logic [8:0] exp;
        do_reset();
        cfg_len = 8'd1; cfg_rows = 8'd2; mac_result = 8'h11;
        in_valid = 1'b1;
        repeat (2) exp_q.push_back(9'h012);
        pulse_start();
        for (int c = 0; c < 40 && emits < 2; c++) begin
            #1;
            credit_ret = 1'b0;
            if (out_valid) begin
                exp = pop_exp();
                n_tests++;
                if (out_data !== exp) begin
                    n_fail++;
                    $display("FAIL simul_data: got %h want %h", out_data, exp);
                end
                if (emits == 1) credit_ret = 1'b1;
                emits++;
            end
            @(negedge clk);
        end
        credit_ret = 1'b0;
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (credits !== 3'd3) begin
            n_fail++;
            $display("FAIL simul_credits: got %0d want 3", credits);
        end
        @(negedge clk);
        credit_ret = 1'b1;
        @(negedge clk);
        credit_ret = 1'b0;
        #1;
        n_tests++;
        if (credits !== 3'd4) begin
            n_fail++;
            $display("FAIL idle_refill: got %0d want 4", credits);
        end
    endtask

    task automatic test_credit_sat();
        do_reset();
        credit_ret = 1'b1;
        @(negedge clk);
        credit_ret = 1'b0;
        #1;
        n_tests++;
        if (credits !== 3'd4 || credits2 !== 3'd2) begin
            n_fail++;
            $display("FAIL credit_sat: got %0d/%0d want 4/2", credits, credits2);
        end
    endtask

    task automatic test_bubbly();
        logic [6:0] pat = 7'b1011001;
        logic got = 1'b0;
        logic [8:0] exp;
        do_reset();
        cfg_len = 8'd4; cfg_rows = 8'd1; mac_result = 8'h7f;
        exp_q.push_back(9'h080);
        pulse_start();
        #1;
        n_tests++;
        if (mac_clr !== 1'b1) begin
            n_fail++;
            $display("FAIL bubbly_clr: got %b want 1", mac_clr);
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = pat[i];
            #1;
            n_tests++;
            if (in_ready !== 1'b1 || mac_en !== pat[i]) begin
                n_fail++;
                $display("FAIL bubbly_beat%0d: got rdy=%b en=%b want 1/%b",
                         i, in_ready, mac_en, pat[i]);
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b0 || mac_en !== 1'b0) begin
            n_fail++;
            $display("FAIL bubbly_drop: got rdy=%b en=%b want 0/0", in_ready, mac_en);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                got = 1'b1;
                exp = pop_exp();
                n_tests++;
                if (out_data !== exp) begin
                    n_fail++;
                    $display("FAIL bubbly_data: got %h want %h", out_data, exp);
                end
            end
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL bubbly_timeout: got no out_valid want one");
        end
    endtask

    task automatic test_cfg_guard();
        int n_en = 0;
        logic got = 1'b0;
        logic [8:0] exp;
        do_reset();
        cfg_len = 8'd0; cfg_rows = 8'd1;
        pulse_start();
        #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL guard_len0: got busy=%b want 0", busy);
        end
        @(negedge clk);
        cfg_len = 8'd2; cfg_rows = 8'd0;
        pulse_start();
        #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL guard_rows0: got busy=%b want 0", busy);
        end
        @(negedge clk);
        cfg_len = 8'd3; cfg_rows = 8'd1; mac_result = 8'h05;
        exp_q.push_back(9'h006);
        pulse_start();
        @(negedge clk);
        start = 1'b1; cfg_len = 8'd1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL guard_in_acc: got rdy=%b want 1", in_ready);
        end
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 30 && !got; c++) begin
            #1;
            if (mac_en) n_en++;
            if (out_valid) begin
                got = 1'b1;
                exp = pop_exp();
                n_tests++;
                if (out_data !== exp) begin
                    n_fail++;
                    $display("FAIL guard_data: got %h want %h", out_data, exp);
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_tests++;
        if (!got || n_en != 3) begin
            n_fail++;
            $display("FAIL guard_len_kept: got en=%0d seen=%b want 3/1", n_en, got);
        end
    endtask

    task automatic test_reset_mid();
        int emits = 0;
        logic [8:0] exp;
        do_reset();
        cfg_len = 8'd1; cfg_rows = 8'd3; mac_result = 8'h00;
        in_valid = 1'b1;
        repeat (3) exp_q.push_back(9'h001);
        pulse_start();
        for (int c = 0; c < 80 && emits < 3; c++) begin
            #1;
            if (out_valid) begin
                exp = pop_exp();
                emits++;
                n_tests++;
                if (out_data !== exp) begin
                    n_fail++;
                    $display("FAIL rmid_data: got %h want %h", out_data, exp);
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (emits != 3 || credits !== 3'd1) begin
            n_fail++;
            $display("FAIL rmid_pre: got emits=%0d cred=%0d want 3/1", emits, credits);
        end
        cfg_len = 8'd4; cfg_rows = 8'd1;
        pulse_start();
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_in_acc: got rdy=%b done=%b want 1/0", in_ready, done);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0
            || credits !== 3'd4) begin
            n_fail++;
            $display("FAIL rmid_after: got busy=%b rdy=%b done=%b cred=%0d want 0/0/0/4",
                     busy, in_ready, done, credits);
        end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_credit_exhaust();
        test_simultaneous();
        test_credit_sat();
        test_bubbly();
        test_cfg_guard();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
